// File: rtl/cu_pkg.sv
// Shared definitions for the accumulator-CPU control unit.
// Contents: sequencer state enum, opcode constants, instruction field widths and a helper
// that derives the instruction width from the register count.
package cu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } cu_state_e;

  // Opcodes occupy the top nibble of ir; a leading 0 selects an ALU instruction.
  localparam int unsigned OPC_W    = 4;
  localparam int unsigned ALU_OP_W = 3;

  localparam logic [OPC_W-1:0] OP_LD  = 4'b1000;
  localparam logic [OPC_W-1:0] OP_ST  = 4'b1001;
  localparam logic [OPC_W-1:0] OP_LDI = 4'b1010;
  localparam logic [OPC_W-1:0] OP_JC  = 4'b1100;
  localparam logic [OPC_W-1:0] OP_HLT = 4'b1111;

  // Jc control bits sit just above the flag index field.
  localparam int unsigned JC_INVERT_OFS = 0;
  localparam int unsigned JC_UNCOND_OFS = 1;

  function automatic int unsigned ir_width(input int unsigned nregs);
    return OPC_W + 2 * $clog2(nregs);
  endfunction

endpackage

// File: rtl/cu_cond.sv
// Branch condition evaluator for Jc.
// Ports:
//   flags  - stored ALU flags
//   idx    - flag index from the instruction
//   invert - invert the selected flag
//   uncond - branch regardless of flags
//   taken  - branch taken
// An index at or beyond NFLAGS reads as a 0 flag.
module cu_cond #(
  parameter int unsigned NFLAGS = 4,
  parameter int unsigned FB     = 2
) (
  input  logic [NFLAGS-1:0] flags,
  input  logic [FB-1:0]     idx,
  input  logic              invert,
  input  logic              uncond,
  output logic              taken
);

  logic flag_sel;

  always_comb begin
    flag_sel = 1'b0;
    for (int unsigned i = 0; i < NFLAGS; i++) begin
      if (idx == FB'(i)) flag_sel = flags[i];
    end
  end

  assign taken = uncond | (invert ^ flag_sel);

endmodule

// File: rtl/control_unit_p.sv
// Multi-cycle FETCH/EXEC/HALT sequencer for the 8-bit accumulator CPU.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   ir, flags            - current instruction and stored ALU flags
//   mem_rdy              - memory ready, only honoured with CU_WAIT_STATES_EN defined
//   mem_rd, mem_wr       - memory strobes; addr_dp selects DP (1) or IP (0) as address
//   ir_we, ip_inc,
//   swap_p, we_reg,
//   we_flags             - commit strobes, effective at the closing posedge
//   di_from_mem, alu_oe  - DI bus source select and ALU drive enable
//   alu_src, alu_op      - ALU B operand register and operation
//   d_src, d_oe          - D bus source register and enable
//   halted               - core halted
// Optional feature: define CU_WAIT_STATES_EN to stall memory cycles until mem_rdy.
module control_unit_p
  import cu_pkg::*;
#(
  parameter int unsigned NREGS  = 4,
  parameter int unsigned NFLAGS = 4,
  parameter int unsigned IR_W   = ir_width(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IR_W-1:0]          ir,
  input  logic [NFLAGS-1:0]        flags,
  input  logic                     mem_rdy,
  output logic                     mem_rd,
  output logic                     mem_wr,
  output logic                     addr_dp,
  output logic                     ir_we,
  output logic                     ip_inc,
  output logic                     swap_p,
  output logic [NREGS-1:0]         we_reg,
  output logic                     di_from_mem,
  output logic [$clog2(NREGS)-1:0] alu_src,
  output logic [ALU_OP_W-1:0]      alu_op,
  output logic                     alu_oe,
  output logic                     we_flags,
  output logic [$clog2(NREGS)-1:0] d_src,
  output logic                     d_oe,
  output logic                     halted
);

  localparam int unsigned RB = $clog2(NREGS);
  localparam int unsigned FB = $clog2(NFLAGS);

  cu_state_e          state_q, state_d;
  logic               rdy;
  logic               jc_taken;
  logic [OPC_W-1:0]   opc;
  logic [NREGS-1:0]   dst_onehot;

`ifdef CU_WAIT_STATES_EN
  assign rdy = mem_rdy;
`else
  logic unused_mem_rdy;
  assign unused_mem_rdy = mem_rdy;
  assign rdy = 1'b1;
`endif

  assign opc        = ir[IR_W-1 -: OPC_W];
  assign dst_onehot = NREGS'(1) << ir[RB-1:0];

  cu_cond #(
    .NFLAGS(NFLAGS),
    .FB    (FB)
  ) u_cond (
    .flags (flags),
    .idx   (ir[FB-1:0]),
    .invert(ir[FB+JC_INVERT_OFS]),
    .uncond(ir[FB+JC_UNCOND_OFS]),
    .taken (jc_taken)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    addr_dp     = 1'b0;
    ir_we       = 1'b0;
    ip_inc      = 1'b0;
    swap_p      = 1'b0;
    we_reg      = '0;
    di_from_mem = 1'b0;
    alu_src     = '0;
    alu_op      = '0;
    alu_oe      = 1'b0;
    we_flags    = 1'b0;
    d_src       = '0;
    d_oe        = 1'b0;
    halted      = 1'b0;

    // Reset silences every output, so a reset mid-EXEC commits nothing.
    if (!rst) begin
      case (state_q)
        FETCH: begin
          mem_rd = 1'b1;
          if (rdy) begin
            ir_we   = 1'b1;
            ip_inc  = 1'b1;
            state_d = EXEC;
          end
        end

        EXEC: begin
          state_d = FETCH;
          if (!ir[IR_W-1]) begin
            alu_op   = ir[IR_W-2 -: ALU_OP_W];
            alu_src  = ir[2*RB-1 -: RB];
            alu_oe   = 1'b1;
            we_reg   = dst_onehot;
            we_flags = 1'b1;
          end else begin
            case (opc)
              OP_LD: begin
                mem_rd      = 1'b1;
                addr_dp     = 1'b1;
                di_from_mem = 1'b1;
                if (rdy) we_reg = dst_onehot;
                else     state_d = EXEC;
              end
              OP_ST: begin
                mem_wr  = 1'b1;
                addr_dp = 1'b1;
                d_src   = ir[RB-1:0];
                d_oe    = 1'b1;
                if (!rdy) state_d = EXEC;
              end
              OP_LDI: begin
                mem_rd      = 1'b1;
                di_from_mem = 1'b1;
                if (rdy) begin
                  we_reg = dst_onehot;
                  ip_inc = 1'b1;
                end else begin
                  state_d = EXEC;
                end
              end
              OP_JC:   swap_p  = jc_taken;
              OP_HLT:  state_d = HALT;
              default: ;
            endcase
          end
        end

        HALT:    halted = 1'b1;
        default: state_d = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit_p.sv
module tb_control_unit_p;

`ifdef CU_WAIT_STATES_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  localparam int PH_FETCH = 0;
  localparam int PH_EXEC  = 1;
  localparam int PH_HALT  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ir;
  logic [3:0] flags;
  logic       mem_rdy;
  logic       mem_rd, mem_wr, addr_dp, ir_we, ip_inc, swap_p;
  logic [3:0] we_reg;
  logic       di_from_mem;
  logic [1:0] alu_src;
  logic [2:0] alu_op;
  logic       alu_oe, we_flags;
  logic [1:0] d_src;
  logic       d_oe, halted;

  int tests = 0;
  int fails = 0;
  int ph    = PH_FETCH;

  always #5 clk = ~clk;

  control_unit_p #(
    .NREGS (4),
    .NFLAGS(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ir         (ir),
    .flags      (flags),
    .mem_rdy    (mem_rdy),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .addr_dp    (addr_dp),
    .ir_we      (ir_we),
    .ip_inc     (ip_inc),
    .swap_p     (swap_p),
    .we_reg     (we_reg),
    .di_from_mem(di_from_mem),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .alu_oe     (alu_oe),
    .we_flags   (we_flags),
    .d_src      (d_src),
    .d_oe       (d_oe),
    .halted     (halted)
  );

  logic [21:0] obs;
  assign obs = {mem_rd, mem_wr, addr_dp, ir_we, ip_inc, swap_p, we_reg, di_from_mem,
                alu_src, alu_op, alu_oe, we_flags, d_src, d_oe, halted};

  // Expected outputs from instruction semantics, packed in the same order as obs.
  function automatic logic [21:0] model(input int phase, input logic [7:0] i,
                                        input logic [3:0] f, input bit rdy_in, input bit r);
    bit rd = 0, wr = 0, adp = 0, irwe = 0, ipi = 0, sw = 0, dim = 0;
    bit aoe = 0, wf = 0, doe = 0, hl = 0;
    logic [3:0] we = '0;
    logic [1:0] as = '0, ds = '0;
    logic [2:0] ao = '0;
    int op   = int'(i) / 16;
    int lo   = int'(i) % 4;
    int mid  = (int'(i) / 4) % 4;
    bit rdy  = WAIT_EN ? rdy_in : 1'b1;
    bit flag, taken;
    if (!r) begin
      if (phase == PH_FETCH) begin
        rd = 1; irwe = rdy; ipi = rdy;
      end else if (phase == PH_EXEC) begin
        if (op < 8) begin
          ao = 3'(op % 8); as = 2'(mid); we = 4'(1 << lo); aoe = 1; wf = 1;
        end else if (op == 8) begin
          rd = 1; adp = 1; dim = 1; we = rdy ? 4'(1 << lo) : 4'd0;
        end else if (op == 9) begin
          wr = 1; adp = 1; ds = 2'(lo); doe = 1;
        end else if (op == 10) begin
          rd = 1; dim = 1; we = rdy ? 4'(1 << lo) : 4'd0; ipi = rdy;
        end else if (op == 12) begin
          flag  = f[lo];
          taken = ((int'(i) / 8) % 2 == 1) || (((int'(i) / 4) % 2 == 1) != flag);
          sw    = taken;
        end
      end else begin
        hl = 1;
      end
    end
    return {rd, wr, adp, irwe, ipi, sw, we, dim, as, ao, aoe, wf, ds, doe, hl};
  endfunction

  function automatic int next_phase(input int phase, input logic [7:0] i, input bit rdy_in,
                                    input bit r);
    int op  = int'(i) / 16;
    bit rdy = WAIT_EN ? rdy_in : 1'b1;
    if (r) return PH_FETCH;
    if (phase == PH_FETCH) return rdy ? PH_EXEC : PH_FETCH;
    if (phase == PH_HALT) return PH_HALT;
    if (op == 15) return PH_HALT;
    if ((op == 8 || op == 9 || op == 10) && !rdy) return PH_EXEC;
    return PH_FETCH;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Moves to mid-cycle and compares the whole output vector against the model.
  task automatic sample(input string tag);
    #4;
    chk(tag, 32'(obs), 32'(model(ph, ir, flags, mem_rdy, rst)));
  endtask

  task automatic advance();
    @(posedge clk);
    ph = next_phase(ph, ir, mem_rdy, rst);
    #1;
  endtask

  task automatic fetch_cycle(input logic [7:0] instr);
    ir = instr;
    sample("fetch");
    chk("fetch_strobes", 32'({mem_rd, ir_we, ip_inc, addr_dp}), 32'(4'b1110));
    advance();
  endtask

  initial begin
    int halt_cnt;
    rst = 1'b1; ir = '0; flags = '0; mem_rdy = 1'b1;
    @(posedge clk);
    ph = PH_FETCH;
    #1;
    sample("reset");
    chk("reset_zero", 32'(obs), 32'd0);
    advance();
    rst = 1'b0;

    // ALU op 3, src 1, dst 2
    fetch_cycle(8'b0_011_01_10);
    sample("alu");
    chk("alu_op", 32'(alu_op), 32'd3);
    chk("alu_src", 32'(alu_src), 32'd1);
    chk("alu_we", 32'(we_reg), 32'b0100);
    chk("alu_flags_oe", 32'({we_flags, alu_oe, di_from_mem}), 32'(3'b110));
    advance();

    // ST from r3
    fetch_cycle(8'b1001_0011);
    sample("st");
    chk("st_strobes", 32'({mem_wr, addr_dp, d_oe}), 32'(3'b111));
    chk("st_dsrc", 32'(d_src), 32'd3);
    chk("st_we", 32'(we_reg), 32'd0);
    advance();

    // Jc inverted flag 1
    fetch_cycle(8'b1100_0101);
    flags = 4'b0010;
    sample("jc_set");
    chk("jc_inv_set", 32'(swap_p), 32'd0);
    advance();
    fetch_cycle(8'b1100_0101);
    flags = 4'b0000;
    sample("jc_clr");
    chk("jc_inv_clr", 32'(swap_p), 32'd1);
    advance();
    for (int k = 0; k < 3; k++) begin
      fetch_cycle(8'b1100_1000);
      flags = 4'($urandom);
      sample("jc_unc");
      chk("jc_uncond", 32'(swap_p), 32'd1);
      advance();
    end

    // LD r1, stalled three EXEC cycles when wait states are enabled
    fetch_cycle(8'b1000_0001);
    if (WAIT_EN) begin
      mem_rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
        sample("ld_wait");
        chk("ld_wait_rd", 32'({mem_rd, addr_dp}), 32'(2'b11));
        chk("ld_wait_we", 32'(we_reg), 32'd0);
        advance();
      end
      mem_rdy = 1'b1;
    end
    sample("ld");
    chk("ld_rd", 32'({mem_rd, addr_dp, di_from_mem}), 32'(3'b111));
    chk("ld_we", 32'(we_reg), 32'b0010);
    advance();
    mem_rdy = 1'b1;
    sample("after_ld");
    chk("after_ld_fetch", 32'({mem_rd, ir_we}), 32'(2'b11));
    advance();
    ph = PH_EXEC;
    rst = 1'b1;
    sample("resync");
    advance();
    rst = 1'b0;

    // HLT, then stay halted until reset
    fetch_cycle(8'hF0);
    sample("hlt_exec");
    chk("hlt_exec_zero", 32'(obs), 32'd0);
    advance();
    for (int k = 0; k < 12; k++) begin
      ir = 8'($urandom); flags = 4'($urandom); mem_rdy = 1'($urandom);
      sample("halt");
      chk("halt_vec", 32'(obs), 32'd1);
      advance();
    end
    rst = 1'b1;
    sample("halt_rst");
    chk("halt_rst_zero", 32'(obs), 32'd0);
    advance();
    rst = 1'b0; mem_rdy = 1'b1;
    fetch_cycle(8'h00);
    advance();

    // Reset during LDI EXEC aborts the commit
    fetch_cycle(8'b1010_0010);
    rst = 1'b1;
    sample("ldi_rst");
    chk("ldi_rst_zero", 32'(obs), 32'd0);
    chk("ldi_rst_noinc", 32'(ip_inc), 32'd0);
    advance();
    rst = 1'b0;
    fetch_cycle(8'h00);
    advance();

    // Randomized run against the model
    halt_cnt = 0;
    for (int n = 0; n < 600; n++) begin
      halt_cnt = (ph == PH_HALT) ? halt_cnt + 1 : 0;
      rst      = (halt_cnt > 3) || ($urandom_range(0, 49) == 0);
      ir       = 8'($urandom);
      flags    = 4'($urandom);
      mem_rdy  = ($urandom_range(0, 3) != 0);
      sample("rand");
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
